sccb_reg_cfg: RTL

//  Register-init sequencer sitting directly upstream of the SCCB write driver.
//  - Waits a power-up delay, then walks an internal ROM of {16-bit reg addr, 8-bit data} entries.
//  - Issues one SCCB write per entry and waits for the driver's done before moving on.
//  - Inserts a long settle after entry 0 (camera soft reset), then flags completion.
//  - clk is the driver's dri_clk: 1 MHz at 50 MHz system clock and 250 kHz SCL.

---
 rtl/sccb_reg_cfg.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sccb_reg_cfg.sv
// sccb_reg_cfg: power-up register-init sequencer feeding an SCCB write driver.
// Ports: clk/rst (sync, active-high), reinit (restart from DONE/ERR), sccb_done (driver write complete);
//        sccb_exec/bit_ctrl/sccb_addr/sccb_data_w (write request to driver), cfg_idx (current entry),
//        init_done (all entries written), cfg_err (entry abandoned after retries).
// Option: define SCCB_CFG_TIMEOUT_EN to enable the done timeout with bounded retries and the ERR state.
module sccb_reg_cfg #(
  parameter logic [7:0]  REG_NUM   = 8'd248,
  parameter logic [19:0] PWR_DLY   = 20'd20000,
  parameter logic [15:0] SWRST_DLY = 16'd5000,
  parameter logic [15:0] GAP       = 16'd4,
  parameter logic [15:0] TIMEOUT   = 16'd1000,
  parameter logic [1:0]  MAX_RETRY = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reinit,
  input  logic        sccb_done,
  output logic        sccb_exec,
  output logic        bit_ctrl,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_data_w,
  output logic [7:0]  cfg_idx,
  output logic        init_done,
  output logic        cfg_err
);
  localparam logic [2:0] PWR_WAIT  = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
  localparam logic [2:0] GAPW      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
  localparam logic [2:0] ERR       = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        done_dly_q;
  logic        done_edge, timeout;
  logic [23:0] rom_d;
  assign done_edge = sccb_done & ~done_dly_q;
`ifdef SCCB_CFG_TIMEOUT_EN
  assign timeout = (state_q == WAIT_DONE) && (cnt_q == 20'(TIMEOUT) - 20'd1);
  assign cfg_err = (state_q == ERR);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout = 1'b0;
  assign cfg_err = 1'b0;
`endif
  // Entry table, looked up on the next index so addr/data are registered as ISSUE is entered.
  always_comb begin
    case (idx_d)
      8'd0:    rom_d = {16'h3008, 8'h82};
      8'd1:    rom_d = {16'h3008, 8'h02};
      8'd2:    rom_d = {16'h3103, 8'h02};
      8'd3:    rom_d = {16'h3017, 8'hff};
      8'd4:    rom_d = {16'h3018, 8'hff};
      8'd5:    rom_d = {16'h3037, 8'h13};
      8'd6:    rom_d = {16'h3108, 8'h01};
      8'd7:    rom_d = {16'h3630, 8'h36};
      8'd8:    rom_d = {16'h3631, 8'h0e};
      8'd9:    rom_d = {16'h3632, 8'he2};
      8'd10:   rom_d = {16'h3633, 8'h12};
      8'd11:   rom_d = {16'h3621, 8'he0};
      8'd12:   rom_d = {16'h3704, 8'ha0};
      8'd13:   rom_d = {16'h3703, 8'h5a};
      8'd14:   rom_d = {16'h3715, 8'h78};
      8'd15:   rom_d = {16'h3717, 8'h01};
      8'd16:   rom_d = {16'h370b, 8'h60};
      8'd17:   rom_d = {16'h3705, 8'h1a};
      8'd18:   rom_d = {16'h3905, 8'h02};
      8'd19:   rom_d = {16'h3906, 8'h10};
      8'd20:   rom_d = {16'h3901, 8'h0a};
      8'd21:   rom_d = {16'h3731, 8'h12};
      8'd22:   rom_d = {16'h3600, 8'h08};
      8'd23:   rom_d = {16'h3601, 8'h33};
      default: rom_d = {16'h0000, 8'h00};
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    case (state_q)
      PWR_WAIT: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == PWR_DLY - 20'd1) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        if (done_edge) begin
          retry_d = '0;
          // Gap counter counts down to zero: loading N-1 yields N gap cycles.
          cnt_d   = (idx_q == 8'd0) ? 20'(SWRST_DLY) - 20'd1 : 20'(GAP) - 20'd1;
          state_d = (idx_q == REG_NUM - 8'd1) ? DONE : GAPW;
        end else if (timeout) begin
          retry_d = retry_q + 2'd1;
          state_d = (retry_q == MAX_RETRY) ? ERR : ISSUE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      GAPW: begin
        cnt_d = cnt_q - 20'd1;
        if (cnt_q == '0) begin
          state_d = ISSUE;
          idx_d   = idx_q + 8'd1;
        end
      end
      default: begin
        if (reinit) begin
          state_d = ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PWR_WAIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      done_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      done_dly_q <= sccb_done;
      if (state_d == ISSUE) {addr_q, data_q} <= rom_d;
    end
  end
  assign sccb_exec   = (state_q == ISSUE);
  assign bit_ctrl    = 1'b1;
  assign sccb_addr   = addr_q;
  assign sccb_data_w = data_q;
  assign cfg_idx     = idx_q;
  assign init_done   = (state_q == DONE);
endmodule
